add_round_key_pipe: RTL

ADD_ROUND_KEY_PIPE -- requirements
Module: add_round_key_pipe

---
 rtl/aes_pkg.sv | 20 ++
 rtl/ark_key_bank.sv | 123 ++++++++++++
 rtl/add_round_key_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the AddRoundKey pipeline.
//
// Contents:
//   AES_BLK_W      - AES state/round-key width (128 bits)
//   AES128_NUM_RK  - number of AES-128 round keys (11)
//   aes_state_t    - 128-bit AES state, column-major bytes, s00 at MSBs
//   idx_in_range() - bounds check shared by the key bank and its users
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES128_NUM_RK = 11;

  typedef logic [AES_BLK_W-1:0] aes_state_t;

  // True when idx addresses a populated slot of a bank of 'depth' entries.
  function automatic logic idx_in_range(input int idx, input int depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/ark_key_bank.sv
// Round-key bank for the AddRoundKey pipeline.
//
// Holds NUM_KEYS round keys of BLK_W bits each in registers (every entry is
// cleared by rst, so this cannot live in a block RAM). One write port and one
// combinational read port with write-first bypass: a write and a read to the
// same valid index in the same cycle return the new data.
//
// Optional feature, macro ARK_ZEROIZE_EN: a zeroize pulse starts a sweep that
// clears one entry per cycle from index 0 upward; zbusy is high for exactly
// NUM_KEYS cycles, and writes are ignored while it is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_we/waddr/wdata  write port; writes to index >= NUM_KEYS are dropped
//   rd_idx              read index
//   rd_key              key at rd_idx (zero when rd_idx is out of range)
//   rd_err              rd_idx >= NUM_KEYS
//   zeroize, zbusy      sweep start / sweep in progress (ARK_ZEROIZE_EN only)
module ark_key_bank
  import aes_pkg::*;
#(
  parameter int  BLK_W    = AES_BLK_W,
  parameter int  NUM_KEYS = AES128_NUM_RK,
  localparam int RND_W    = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [RND_W-1:0] key_waddr,
  input  logic [BLK_W-1:0] key_wdata,
  input  logic [RND_W-1:0] rd_idx,
  output logic [BLK_W-1:0] rd_key,
`ifdef ARK_ZEROIZE_EN
  input  logic             zeroize,
  output logic             zbusy,
`endif
  output logic             rd_err
);

  logic [NUM_KEYS-1:0][BLK_W-1:0] bank_w;
  logic                           wr_ok;
  logic                           rd_ok;

`ifdef ARK_ZEROIZE_EN
  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_KEYS - 1);

  logic             zbusy_q, zbusy_d;
  logic [RND_W-1:0] zidx_q,  zidx_d;

  // Sweep controller: the pulse is only honoured while idle; the last
  // cleared index ends the sweep so zbusy spans exactly NUM_KEYS cycles.
  always_comb begin
    zbusy_d = zbusy_q;
    zidx_d  = zidx_q;
    if (zbusy_q) begin
      if (zidx_q == LAST_IDX) begin
        zbusy_d = 1'b0;
        zidx_d  = '0;
      end else begin
        zidx_d = zidx_q + RND_W'(1);
      end
    end else if (zeroize) begin
      zbusy_d = 1'b1;
      zidx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zbusy_q <= 1'b0;
      zidx_q  <= '0;
    end else begin
      zbusy_q <= zbusy_d;
      zidx_q  <= zidx_d;
    end
  end

  assign zbusy = zbusy_q;
  assign wr_ok = key_we && !zbusy_q && idx_in_range(32'(key_waddr), NUM_KEYS);
`else
  assign wr_ok = key_we && idx_in_range(32'(key_waddr), NUM_KEYS);
`endif

  // One register per entry; each has its own clear and write select.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_entry
    logic [BLK_W-1:0] entry_q;
    logic             wr_sel;
    logic             clr_sel;

    assign wr_sel = wr_ok && (key_waddr == RND_W'(gi));
`ifdef ARK_ZEROIZE_EN
    assign clr_sel = zbusy_q && (zidx_q == RND_W'(gi));
`else
    assign clr_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst || clr_sel) begin
        entry_q <= '0;
      end else if (wr_sel) begin
        entry_q <= key_wdata;
      end
    end

    assign bank_w[gi] = entry_q;
  end

  assign rd_ok  = idx_in_range(32'(rd_idx), NUM_KEYS);
  assign rd_err = !rd_ok;

  // Out-of-range reads return zero so the datapath XOR passes state through.
  always_comb begin
    rd_key = '0;
    if (rd_ok) begin
      if (wr_ok && (key_waddr == rd_idx)) begin
        rd_key = key_wdata;
      end else begin
        rd_key = bank_w[rd_idx];
      end
    end
  end

endmodule

// File: rtl/add_round_key_pipe.sv
// AES AddRoundKey as a two-stage valid/ready pipeline.
//
// S1 captures the input state together with the selected round key at the
// input-transfer cycle, so later key writes never touch in-flight data.
// S2 registers state ^ key and presents it on the output, holding it stable
// until the downstream accepts it. One transfer per cycle is sustained.
// An out-of-range in_round passes the state unmodified with out_err set.
//
// Optional feature, macro ARK_ZEROIZE_EN: adds zeroize (in) / zbusy (out);
// the key bank is swept to zero over NUM_KEYS cycles and the input is
// stalled while the sweep runs. Without it the bank clears only on rst.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   key_we, key_waddr, key_wdata     round-key write port
//   in_valid, in_ready               input handshake
//   in_state, in_round               state and round-key index
//   out_valid, out_ready             output handshake
//   out_state, out_round, out_err    keyed state, carried index, range error
//   zeroize, zbusy                   key-bank sweep (ARK_ZEROIZE_EN only)
module add_round_key_pipe
  import aes_pkg::*;
#(
  parameter int  BLK_W    = AES_BLK_W,
  parameter int  NUM_KEYS = AES128_NUM_RK,
  localparam int RND_W    = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [RND_W-1:0] key_waddr,
  input  logic [BLK_W-1:0] key_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_state,
  input  logic [RND_W-1:0] in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_state,
  output logic [RND_W-1:0] out_round,
`ifdef ARK_ZEROIZE_EN
  input  logic             zeroize,
  output logic             zbusy,
`endif
  output logic             out_err
);

  logic [BLK_W-1:0] key_rd;
  logic             key_rerr;
  logic             zbusy_w;

  ark_key_bank #(
    .BLK_W    (BLK_W),
    .NUM_KEYS (NUM_KEYS)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .rd_idx    (in_round),
    .rd_key    (key_rd),
`ifdef ARK_ZEROIZE_EN
    .zeroize   (zeroize),
    .zbusy     (zbusy_w),
`endif
    .rd_err    (key_rerr)
  );

`ifdef ARK_ZEROIZE_EN
  assign zbusy = zbusy_w;
`else
  assign zbusy_w = 1'b0;
`endif

  // Stage 1: captured state, key and index.
  logic             s1_v_q,     s1_v_d;
  logic [BLK_W-1:0] s1_state_q, s1_state_d;
  logic [BLK_W-1:0] s1_key_q,   s1_key_d;
  logic [RND_W-1:0] s1_round_q, s1_round_d;
  logic             s1_err_q,   s1_err_d;

  // Stage 2: output register.
  logic             s2_v_q,      s2_v_d;
  logic [BLK_W-1:0] out_state_q, out_state_d;
  logic [RND_W-1:0] out_round_q, out_round_d;
  logic             out_err_q,   out_err_d;

  logic accept;
  logic s2_load;

  // S1 can take new data whenever it is empty or will hand off to S2 this
  // cycle; S2 can take S1 whenever it is empty or is being drained.
  assign in_ready = !zbusy_w && (!s1_v_q || !s2_v_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_v_q && (!s2_v_q || out_ready);

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_state_d = s1_state_q;
    s1_key_d   = s1_key_q;
    s1_round_d = s1_round_q;
    s1_err_d   = s1_err_q;
    if (accept) begin
      s1_v_d     = 1'b1;
      s1_state_d = in_state;
      s1_key_d   = key_rd;
      s1_round_d = in_round;
      s1_err_d   = key_rerr;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    s2_v_d      = s2_v_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_err_d   = out_err_q;
    if (s2_load) begin
      s2_v_d      = 1'b1;
      out_state_d = s1_state_q ^ s1_key_q;
      out_round_d = s1_round_q;
      out_err_d   = s1_err_q;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_state_q  <= '0;
      s1_key_q    <= '0;
      s1_round_q  <= '0;
      s1_err_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_state_q  <= s1_state_d;
      s1_key_q    <= s1_key_d;
      s1_round_q  <= s1_round_d;
      s1_err_q    <= s1_err_d;
      s2_v_q      <= s2_v_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_err   = out_err_q;

endmodule
